// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter. Frame is a start bit, 5..9 data bits sent LSB first,
// optional even/odd parity and 1..2 stop bits. Characters arrive over a valid/ready handshake.
module uart_tx_cfg #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_line,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);

   if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
      $error("uart_tx_cfg: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state,    w_state;
   logic [CNT_W-1:0]     r_baud_cnt, w_baud_cnt;
   logic [IDX_W-1:0]     r_bit_idx,  w_bit_idx;
   logic [DATA_BITS-1:0] r_shift,    w_shift;
   logic                 r_par_bit,  w_par_bit;
   logic                 r_stop_idx, w_stop_idx;
   logic                 r_line,     w_line;
   logic                 r_ready,    w_ready;
   logic                 r_busy,     w_busy;
   logic                 r_done,     w_done;
   logic                 w_bit_end;
   logic                 w_accept;

   assign w_bit_end = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign w_accept  = tx_valid && r_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_stop_idx <= 1'b0;
         r_line     <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_baud_cnt <= w_baud_cnt;
         r_bit_idx  <= w_bit_idx;
         r_shift    <= w_shift;
         r_par_bit  <= w_par_bit;
         r_stop_idx <= w_stop_idx;
         r_line     <= w_line;
         r_ready    <= w_ready;
         r_busy     <= w_busy;
         r_done     <= w_done;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_baud_cnt = r_baud_cnt;
      w_bit_idx  = r_bit_idx;
      w_shift    = r_shift;
      w_par_bit  = r_par_bit;
      w_stop_idx = r_stop_idx;
      w_line     = r_line;
      w_ready    = r_ready;
      w_busy     = r_busy;
      w_done     = 1'b0;

      // Bit timer only runs inside a frame, so every frame is aligned to its accept edge.
      if (r_state != S_IDLE) begin
         w_baud_cnt = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            w_baud_cnt = '0;
            if (w_accept) begin
               w_shift    = tx_data;
               w_par_bit  = (PARITY == 2) ? ~^tx_data : ^tx_data;
               w_bit_idx  = '0;
               w_stop_idx = 1'b0;
               w_state    = S_START;
               w_line     = 1'b0;
               w_ready    = 1'b0;
               w_busy     = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state = S_DATA;
               w_line  = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                  w_bit_idx = '0;
                  if (PARITY != 0) begin
                     w_state = S_PARITY;
                     w_line  = r_par_bit;
                  end else begin
                     w_state = S_STOP;
                     w_line  = 1'b1;
                  end
               end else begin
                  w_shift   = r_shift >> 1;
                  w_line    = r_shift[1];
                  w_bit_idx = r_bit_idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state = S_STOP;
               w_line  = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (STOP_BITS == 2 && !r_stop_idx) begin
                  w_stop_idx = 1'b1;
               end else begin
                  w_stop_idx = 1'b0;
                  w_state    = S_IDLE;
                  w_ready    = 1'b1;
                  w_busy     = 1'b0;
                  w_done     = 1'b1;
               end
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign tx_ready = r_ready;
   assign tx_line  = r_line;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) share one stimulus stream and are
// checked every cycle against a frame-level model, plus literal frame/latency expectations.
module tb_uart_tx_cfg;

   localparam int DIV = 10;
   localparam int NI  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx_valid = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic [NI-1:0] line_o, ready_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   logic [15:0]   m_frame [NI];
   int            m_cnt   [NI];
   logic [NI-1:0] m_busy, m_ready, m_done;

   logic [15:0]   g_frame [NI];
   int            g_lat   [NI];
   logic [7:0]    b2b_a, b2b_b;

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u_8n1 (.clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_o[0]), .tx_data(tx_data),
             .tx_line(line_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
   uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
      u_8e1 (.clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_o[1]), .tx_data(tx_data),
             .tx_line(line_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
   uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
      u_8o1 (.clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_o[2]), .tx_data(tx_data),
             .tx_line(line_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
   uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
      u_7n2 (.clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(ready_o[3]), .tx_data(tx_data[6:0]),
             .tx_line(line_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

   function automatic int db(input int k);
      return (k == 3) ? 7 : 8;
   endfunction

   function automatic int par(input int k);
      return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
   endfunction

   function automatic int stp(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   function automatic int nbits(input int k);
      return 1 + db(k) + ((par(k) != 0) ? 1 : 0) + stp(k);
   endfunction

   // Frame as a bit list, index 0 = start bit; unused upper positions read as idle-high.
   function automatic logic [15:0] build(input int k, input logic [7:0] d);
      logic [15:0] f;
      logic        p;
      f    = '1;
      p    = 1'b0;
      f[0] = 1'b0;
      for (int i = 0; i < db(k); i++) begin
         f[1 + i] = d[i];
         p        = p ^ d[i];
      end
      if (par(k) == 1) f[db(k) + 1] = p;
      if (par(k) == 2) f[db(k) + 1] = ~p;
      return f;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NI; k++) begin
            m_busy[k]  <= 1'b0;
            m_ready[k] <= 1'b1;
            m_done[k]  <= 1'b0;
            m_cnt[k]   <= 0;
            m_frame[k] <= '1;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (tx_valid && m_ready[k]) begin
               m_frame[k] <= build(k, tx_data);
               m_cnt[k]   <= 0;
               m_busy[k]  <= 1'b1;
               m_ready[k] <= 1'b0;
               m_done[k]  <= 1'b0;
            end else if (m_busy[k]) begin
               m_cnt[k] <= m_cnt[k] + 1;
               if (m_cnt[k] + 1 == nbits(k) * DIV) begin
                  m_busy[k]  <= 1'b0;
                  m_ready[k] <= 1'b1;
                  m_done[k]  <= 1'b1;
               end else begin
                  m_done[k] <= 1'b0;
               end
            end else begin
               m_done[k] <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk("line",  k, 32'(line_o[k]),  32'(m_busy[k] ? m_frame[k][m_cnt[k] / DIV] : 1'b1));
         chk("ready", k, 32'(ready_o[k]), 32'(m_ready[k]));
         chk("busy",  k, 32'(busy_o[k]),  32'(m_busy[k]));
         chk("done",  k, 32'(done_o[k]),  32'(m_done[k]));
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (ready_o !== 4'hF && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", 0, 32'(ready_o), 32'hF);
      @(negedge clk);
   endtask

   // Sends one character to all instances, recording mid-bit samples and the tx_done cycle.
   task automatic run_frame(input logic [7:0] d, input int inj_on, input int inj_off);
      for (int k = 0; k < NI; k++) begin
         g_frame[k] = '0;
         g_lat[k]   = 0;
      end
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int c = 1; c <= 130; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (c % DIV == DIV / 2 && c / DIV < nbits(k)) g_frame[k][c / DIV] = line_o[k];
            if (done_o[k] === 1'b1 && g_lat[k] == 0) g_lat[k] = c;
         end
         if (inj_on != 0 && c == inj_on) begin
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
         end
         if (inj_on != 0 && c == inj_off) begin
            chk("ready_held_low", 0, 32'(ready_o[0]), 32'h0);
            tx_valid = 1'b0;
         end
      end
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_line",  0, 32'(line_o),  32'hF);
      chk("rst_ready", 0, 32'(ready_o), 32'hF);
      chk("rst_busy",  0, 32'(busy_o),  32'h0);
      chk("rst_done",  0, 32'(done_o),  32'h0);
      rst = 1'b0;
      @(negedge clk);

      run_frame(8'hA5, 0, 0);
      chk("8n1_a5_frame", 0, 32'(g_frame[0]), 32'h34A);
      chk("8n1_a5_lat",   0, 32'(g_lat[0]),   32'd100);

      run_frame(8'h07, 0, 0);
      chk("8e1_07_frame", 1, 32'(g_frame[1]), 32'h60E);
      chk("8e1_07_lat",   1, 32'(g_lat[1]),   32'd110);
      chk("8o1_07_frame", 2, 32'(g_frame[2]), 32'h40E);

      run_frame(8'h00, 0, 0);
      chk("8e1_00_frame", 1, 32'(g_frame[1]), 32'h400);

      run_frame(8'h55, 0, 0);
      chk("7n2_55_frame", 3, 32'(g_frame[3]), 32'h3AA);
      chk("7n2_55_lat",   3, 32'(g_lat[3]),   32'd100);

      // Back-to-back: tx_valid stays high across the first tx_done.
      b2b_a    = '0;
      b2b_b    = '0;
      tx_valid = 1'b1;
      tx_data  = 8'h01;
      @(negedge clk);
      tx_data = 8'h80;
      for (int c = 1; c <= 230; c++) begin
         @(negedge clk);
         if (c >= 15 && c <= 85 && c % DIV == 5) b2b_a[(c - 15) / DIV] = line_o[0];
         if (c >= 116 && c <= 186 && c % DIV == 6) b2b_b[(c - 116) / DIV] = line_o[0];
         if (c == 100) chk("b2b_done", 0, 32'(done_o[0]), 32'h1);
         if (c == 101) chk("b2b_start", 0, 32'(line_o[0]), 32'h0);
         if (c == 111) tx_valid = 1'b0;
      end
      chk("b2b_first",  0, 32'(b2b_a), 32'h01);
      chk("b2b_second", 0, 32'(b2b_b), 32'h80);
      wait_idle();

      run_frame(8'hA5, 30, 60);
      chk("ignore_ff_frame", 0, 32'(g_frame[0]), 32'h34A);
      chk("ignore_ff_lat",   0, 32'(g_lat[0]),   32'd100);

      // Asynchronous reset in the middle of data bit 3.
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (44) @(negedge clk);
      chk("pre_rst_bit3", 0, 32'(line_o[0]), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_line",  0, 32'(line_o),  32'hF);
      chk("async_rst_ready", 0, 32'(ready_o), 32'hF);
      chk("async_rst_busy",  0, 32'(busy_o),  32'h0);
      chk("async_rst_done",  0, 32'(done_o),  32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_frame(8'h3C, 0, 0);
      chk("post_rst_3c_frame", 0, 32'(g_frame[0]), 32'h278);
      chk("post_rst_3c_lat",   0, 32'(g_lat[0]),   32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
